smpc_pad_scanner: RTL and testbench

- Sequences the two SMPC peripheral ports to read standard digital pads.
- Drives the TH/TR select lines through four phases per port and samples the 4-bit data nibble in each phase.
- Assembles per-port status, ID and 16-bit button words; the SMPC command sequencer loads these into OREG during INTBACK peripheral collection.
- Sits between the SMPC core and the P1/P2 pin groups and replaces the fixed JOY1 path.

---
 rtl/smpc_pad_scanner_if.sv | 34 +++
 rtl/smpc_pad_scanner.sv | 190 +++++++++++++++++++
 tb/tb_smpc_pad_scanner.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/smpc_pad_scanner_if.sv
// SMPC pad scanner bus: core-side control/results plus the P1/P2 pin groups.
// The master side is the SMPC core together with the pins; the scanner is the slave.
interface smpc_pad_scanner_if;
    logic        CE;
    logic        REQ;
    logic        ABORT;
    logic [1:0]  PORT_EN;
    logic [6:0]  P1I;
    logic [6:0]  P2I;
    logic [6:0]  P1O;
    logic [6:0]  P1OE;
    logic [6:0]  P2O;
    logic [6:0]  P2OE;
    logic        BUSY;
    logic        DONE;
    logic [7:0]  STAT1;
    logic [7:0]  ID1;
    logic [15:0] DATA1;
    logic [7:0]  STAT2;
    logic [7:0]  ID2;
    logic [15:0] DATA2;

    modport master (
        output CE, REQ, ABORT, PORT_EN, P1I, P2I,
        input  P1O, P1OE, P2O, P2OE, BUSY, DONE,
        input  STAT1, ID1, DATA1, STAT2, ID2, DATA2
    );

    modport slave (
        input  CE, REQ, ABORT, PORT_EN, P1I, P2I,
        output P1O, P1OE, P2O, P2OE, BUSY, DONE,
        output STAT1, ID1, DATA1, STAT2, ID2, DATA2
    );
endinterface

// File: rtl/smpc_pad_scanner.sv
// SMPC digital pad scanner: walks TH/TR through four phases per port,
// samples each nibble and publishes status/ID/buttons atomically at scan end.
module smpc_pad_scanner #(
    parameter int unsigned SETTLE_CYC = 16
) (
    input  logic CLK,
    input  logic RST_N,
    smpc_pad_scanner_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [7:0] CNT_LD = 8'(SETTLE_CYC);
    localparam logic [6:0] PIN_REL = 7'h60;
    localparam logic [6:0] OE_SEL = 7'h60;

    state_t            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic              port_q, port_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [11:0]       cap_q, cap_d;
    logic [1:0]        sh_ok_q, sh_ok_d;
    logic [1:0][15:0]  sh_dat_q, sh_dat_d;
    logic [1:0]        out_ok_q, out_ok_d;
    logic [1:0][15:0]  out_dat_q, out_dat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [6:0]        p1o_q, p1o_d, p1oe_q, p1oe_d;
    logic [6:0]        p2o_q, p2o_d, p2oe_q, p2oe_d;
    logic [6:0]        p1_m_q, p1_s_q, p2_m_q, p2_s_q;
    logic [3:0]        nib;
    logic              pad_ok;

    // Two-flop pin synchronizers, free-running on CLK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p1_m_q <= '0;
            p1_s_q <= '0;
            p2_m_q <= '0;
            p2_s_q <= '0;
        end else begin
            p1_m_q <= bus.P1I;
            p1_s_q <= p1_m_q;
            p2_m_q <= bus.P2I;
            p2_s_q <= p2_m_q;
        end
    end

    // Scan state, shadows, published results and pin drivers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            port_q    <= 1'b0;
            cnt_q     <= '0;
            cap_q     <= '1;
            sh_ok_q   <= '0;
            sh_dat_q  <= '1;
            out_ok_q  <= '0;
            out_dat_q <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            p1o_q     <= PIN_REL;
            p1oe_q    <= '0;
            p2o_q     <= PIN_REL;
            p2oe_q    <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            port_q    <= port_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            sh_ok_q   <= sh_ok_d;
            sh_dat_q  <= sh_dat_d;
            out_ok_q  <= out_ok_d;
            out_dat_q <= out_dat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            p1o_q     <= p1o_d;
            p1oe_q    <= p1oe_d;
            p2o_q     <= p2o_d;
            p2oe_q    <= p2oe_d;
        end
    end

    // Next-state: sequencing, nibble capture, port wrap-up, pin select.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        port_d    = port_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        sh_ok_d   = sh_ok_q;
        sh_dat_d  = sh_dat_q;
        out_ok_d  = out_ok_q;
        out_dat_d = out_dat_q;
        busy_d    = busy_q;
        done_d    = done_q;
        nib       = port_q ? p2_s_q[3:0] : p1_s_q[3:0];
        pad_ok    = (nib[2:0] == 3'b100);

        if (bus.CE) begin
            done_d = 1'b0;
            if (bus.ABORT && state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (bus.REQ && !bus.ABORT) begin
                            busy_d   = 1'b1;
                            sh_ok_d  = '0;
                            sh_dat_d = '1;
                            phase_d  = 2'd0;
                            cnt_d    = CNT_LD;
                            port_d   = ~bus.PORT_EN[0];
                            state_d  = (bus.PORT_EN == 2'b00) ? ST_DONE : ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_q == 8'd0) state_d = ST_SAMPLE;
                        else cnt_d = cnt_q - 8'd1;
                    end
                    ST_SAMPLE: begin
                        if (phase_q != 2'd3) begin
                            // Nibbles shift in so ph0 lands in the top nibble.
                            cap_d   = {cap_q[7:0], nib};
                            phase_d = phase_q + 2'd1;
                            cnt_d   = CNT_LD;
                            state_d = ST_SETTLE;
                        end else begin
                            // Last phase doubles as port wrap-up: ID check and hand-off.
                            sh_ok_d[port_q]  = pad_ok;
                            sh_dat_d[port_q] = pad_ok ? {cap_q, nib[3], 3'b111} : 16'hFFFF;
                            if (!port_q && bus.PORT_EN[1]) begin
                                port_d  = 1'b1;
                                phase_d = 2'd0;
                                cnt_d   = CNT_LD;
                                state_d = ST_SETTLE;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        out_ok_d  = sh_ok_q;
                        out_dat_d = sh_dat_q;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        p1o_d  = PIN_REL;
        p1oe_d = '0;
        p2o_d  = PIN_REL;
        p2oe_d = '0;
        if (state_d == ST_SETTLE || state_d == ST_SAMPLE) begin
            if (port_d) begin
                p2o_d  = {phase_d, 5'b0};
                p2oe_d = OE_SEL;
            end else begin
                p1o_d  = {phase_d, 5'b0};
                p1oe_d = OE_SEL;
            end
        end
    end

    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
    assign bus.P1O   = p1o_q;
    assign bus.P1OE  = p1oe_q;
    assign bus.P2O   = p2o_q;
    assign bus.P2OE  = p2oe_q;
    assign bus.STAT1 = out_ok_q[0] ? 8'hF1 : 8'hF0;
    assign bus.ID1   = out_ok_q[0] ? 8'h02 : 8'hFF;
    assign bus.DATA1 = out_dat_q[0];
    assign bus.STAT2 = out_ok_q[1] ? 8'hF1 : 8'hF0;
    assign bus.ID2   = out_ok_q[1] ? 8'h02 : 8'hFF;
    assign bus.DATA2 = out_dat_q[1];

endmodule

// File: tb/tb_smpc_pad_scanner.sv
// Randomized self-checking bench for smpc_pad_scanner against a pad-level
// model of what each scan must publish and how many CE ticks it takes.
module tb_smpc_pad_scanner;

    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    smpc_pad_scanner_if bus ();

    smpc_pad_scanner #(.SETTLE_CYC(S)) u_dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    logic [3:0]  pad [2][4];
    logic [7:0]  e_stat [2];
    logic [7:0]  e_id [2];
    logic [15:0] e_dat [2];

    int n_err = 0;
    int n_chk = 0;
    int ce_div = 1;
    int ce_ph = 0;
    int oe1_cnt = 0;
    int oe2_cnt = 0;
    int done_cnt = 0;

    // Pads answer whatever TH/TR currently select.
    always_comb begin
        bus.P1I = {3'b111, pad[0][bus.P1O[6:5]]};
        bus.P2I = {3'b111, pad[1][bus.P2O[6:5]]};
    end

    // Activity monitors: pin-enable cycles and DONE pulses consumed.
    always @(posedge clk) begin
        if (bus.P1OE != 7'h00) oe1_cnt <= oe1_cnt + 1;
        if (bus.P2OE != 7'h00) oe2_cnt <= oe2_cnt + 1;
        if (bus.DONE && bus.CE) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        ce_ph = (ce_ph + 1) % ce_div;
        bus.CE = (ce_ph == 0);
    endtask

    function automatic void model(input logic [1:0] en);
        for (int p = 0; p < 2; p++) begin
            if (en[p] && pad[p][3][2:0] == 3'b100) begin
                e_stat[p] = 8'hF1;
                e_id[p] = 8'h02;
                e_dat[p] = {pad[p][0], pad[p][1], pad[p][2], pad[p][3][3], 3'b111};
            end else begin
                e_stat[p] = 8'hF0;
                e_id[p] = 8'hFF;
                e_dat[p] = 16'hFFFF;
            end
        end
    endfunction

    task automatic set_pads(input bit g0, input bit g1);
        bit g;
        for (int p = 0; p < 2; p++) begin
            g = (p == 0) ? g0 : g1;
            for (int ph = 0; ph < 3; ph++) pad[p][ph] = 4'($urandom_range(0, 15));
            if (g) pad[p][3] = {1'($urandom_range(0, 1)), 3'b100};
            else pad[p][3] = {1'($urandom_range(0, 1)), 3'($urandom_range(5, 7))};
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".stat1"}, 32'(bus.STAT1), 32'(e_stat[0]));
        chk({tag, ".id1"}, 32'(bus.ID1), 32'(e_id[0]));
        chk({tag, ".data1"}, 32'(bus.DATA1), 32'(e_dat[0]));
        chk({tag, ".stat2"}, 32'(bus.STAT2), 32'(e_stat[1]));
        chk({tag, ".id2"}, 32'(bus.ID2), 32'(e_id[1]));
        chk({tag, ".data2"}, 32'(bus.DATA2), 32'(e_dat[1]));
    endtask

    task automatic run_scan(input logic [1:0] en, input int abort_at, input int req2_at);
        int ticks;
        int o1;
        int o2;
        int d0;
        int lat;
        logic ce_at;
        logic aborted;
        ticks = 0;
        aborted = 1'b0;
        while (!bus.CE) cyc();
        o1 = oe1_cnt;
        o2 = oe2_cnt;
        d0 = done_cnt;
        bus.PORT_EN = en;
        bus.REQ = 1'b1;
        cyc();
        bus.REQ = 1'b0;
        chk("busy_set", 32'(bus.BUSY), 32'd1);
        lat = (int'(en[0]) + int'(en[1])) * 4 * (S + 2) + 1;
        for (int k = 0; k < 4000 && !bus.DONE && !aborted; k++) begin
            ce_at = bus.CE;
            if (ce_at && ticks == abort_at) bus.ABORT = 1'b1;
            if (ce_at && ticks == req2_at) bus.REQ = 1'b1;
            cyc();
            if (bus.ABORT) aborted = 1'b1;
            bus.ABORT = 1'b0;
            bus.REQ = 1'b0;
            if (ce_at) ticks++;
        end
        if (aborted) begin
            chk("abort_busy", 32'(bus.BUSY), 32'd0);
            chk("abort_done", 32'(bus.DONE), 32'd0);
            chk("abort_p1oe", 32'(bus.P1OE), 32'd0);
            chk("abort_p2oe", 32'(bus.P2OE), 32'd0);
            chk("abort_p2o", 32'(bus.P2O), 32'h60);
            check_outs("abort");
            repeat (150) cyc();
            chk("abort_nodone", 32'(done_cnt - d0), 32'd0);
            return;
        end
        chk("done_seen", 32'(bus.DONE), 32'd1);
        chk("latency", 32'(ticks), 32'(lat));
        chk("busy_clr", 32'(bus.BUSY), 32'd0);
        model(en);
        check_outs("scan");
        chk("p1_activity", 32'(oe1_cnt != o1), 32'(en[0]));
        chk("p2_activity", 32'(oe2_cnt != o2), 32'(en[1]));
        if (ce_div > 1) begin
            cyc();
            chk("done_hold", 32'(bus.DONE), 32'd1);
            while (!bus.CE) cyc();
            cyc();
            chk("done_clr_ce", 32'(bus.DONE), 32'd0);
        end else begin
            cyc();
            chk("done_pulse", 32'(bus.DONE), 32'd0);
        end
        if (req2_at >= 0) begin
            repeat (200) cyc();
            chk("req2_ignored", 32'(done_cnt - d0), 32'd1);
            chk("req2_idle", 32'(bus.BUSY), 32'd0);
        end
    endtask

    initial begin
        bus.CE = 1'b0;
        bus.REQ = 1'b0;
        bus.ABORT = 1'b0;
        bus.PORT_EN = 2'b00;
        for (int p = 0; p < 2; p++)
            for (int ph = 0; ph < 4; ph++) pad[p][ph] = 4'hF;
        for (int p = 0; p < 2; p++) begin
            e_stat[p] = 8'hF0;
            e_id[p] = 8'hFF;
            e_dat[p] = 16'hFFFF;
        end

        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_p1o", 32'(bus.P1O), 32'h60);
        chk("rst_p1oe", 32'(bus.P1OE), 32'd0);
        chk("rst_p2o", 32'(bus.P2O), 32'h60);
        chk("rst_p2oe", 32'(bus.P2OE), 32'd0);
        check_outs("rst");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        ce_div = 1;
        cyc();
        cyc();

        // Both ports, fixed nibbles A/5/C/4.
        for (int p = 0; p < 2; p++) begin
            pad[p][0] = 4'hA;
            pad[p][1] = 4'h5;
            pad[p][2] = 4'hC;
            pad[p][3] = 4'h4;
        end
        run_scan(2'b11, -1, -1);

        // Port 1 only, unknown ID.
        pad[0][3] = 4'h7;
        run_scan(2'b01, -1, -1);

        // Nothing enabled.
        run_scan(2'b00, -1, -1);

        // Random pads and enables.
        for (int i = 0; i < 6; i++) begin
            set_pads(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) != 0));
            run_scan(2'($urandom_range(0, 3)), -1, -1);
        end

        // Abort during port 2 phase 2 after a good scan.
        set_pads(1'b1, 1'b1);
        run_scan(2'b11, -1, -1);
        set_pads(1'b1, 1'b1);
        run_scan(2'b11, 4 * (S + 2) + 2 * (S + 2) + 3, -1);

        // CE one tick in three.
        ce_div = 3;
        set_pads(1'b1, 1'b1);
        run_scan(2'b11, -1, -1);
        set_pads(1'b0, 1'b1);
        run_scan(2'b11, -1, -1);
        ce_div = 1;
        cyc();

        // Second REQ while busy is dropped.
        set_pads(1'b1, 1'b1);
        run_scan(2'b11, -1, 10);

        // Reset in the middle of a SETTLE.
        while (!bus.CE) cyc();
        bus.PORT_EN = 2'b11;
        bus.REQ = 1'b1;
        cyc();
        bus.REQ = 1'b0;
        cyc();
        cyc();
        chk("pre_rst_p1oe", 32'(bus.P1OE), 32'h60);
        #2 rst_n = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) begin
            e_stat[p] = 8'hF0;
            e_id[p] = 8'hFF;
            e_dat[p] = 16'hFFFF;
        end
        chk("mrst_busy", 32'(bus.BUSY), 32'd0);
        chk("mrst_p1oe", 32'(bus.P1OE), 32'd0);
        chk("mrst_p1o", 32'(bus.P1O), 32'h60);
        chk("mrst_p2oe", 32'(bus.P2OE), 32'd0);
        check_outs("mrst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("post_rst_busy", 32'(bus.BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
